// File: rtl/tug_scoreboard.sv
// Tug-of-war scoreboard: credits each decoded round win once, pulses round_reset, freezes at WIN_SCORE.
// Optional score digit decode enabled by defining SCOREBOARD_HEX_EN.
module tug_scoreboard #(
  parameter int WIN_SCORE = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] hex_in,
  output logic       round_reset,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       match_over,
  output logic [6:0] HEX_L,
  output logic [6:0] HEX_R
);

  localparam logic [6:0] HEX_OFF   = 7'b1111111;
  localparam logic [6:0] HEX_LEFT  = 7'b0100100;
  localparam logic [6:0] HEX_RIGHT = 7'b1111001;
  localparam logic [3:0] WIN       = 4'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, CLEAR, WAIT_OFF, DONE} state_t;

  state_t     state_q;
  logic [3:0] score_l_q, score_r_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      score_l_q <= '0;
      score_r_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Saturation guard keeps scores bounded even if the win check were bypassed
          if (hex_in == HEX_LEFT && score_l_q < WIN) begin
            score_l_q <= score_l_q + 4'd1;
            state_q   <= CLEAR;
          end else if (hex_in == HEX_RIGHT && score_r_q < WIN) begin
            score_r_q <= score_r_q + 4'd1;
            state_q   <= CLEAR;
          end
        end
        CLEAR:    state_q <= WAIT_OFF;
        WAIT_OFF: if (hex_in == HEX_OFF)
                    state_q <= (score_l_q == WIN || score_r_q == WIN) ? DONE : IDLE;
        DONE:     state_q <= DONE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign round_reset = (state_q == CLEAR);
  assign match_over  = (state_q == DONE);
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;

`ifdef SCOREBOARD_HEX_EN
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Once the match is decided only the winner's digit stays lit
  always_comb begin
    HEX_L = seg7(score_l_q);
    HEX_R = seg7(score_r_q);
    if (state_q == DONE && score_l_q != WIN) HEX_L = 7'b1111111;
    if (state_q == DONE && score_r_q != WIN) HEX_R = 7'b1111111;
  end
`else
  assign HEX_L = 7'b1111111;
  assign HEX_R = 7'b1111111;
`endif

endmodule
